// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'h0;
    localparam logic [3:0] OP_SUB       = 4'h1;
    localparam logic [3:0] OP_AND       = 4'h2;
    localparam logic [3:0] OP_OR        = 4'h3;
    localparam logic [3:0] OP_XOR       = 4'h4;
    localparam logic [3:0] OP_SHL       = 4'h5;
    localparam logic [3:0] OP_SHR       = 4'h6;
    localparam logic [3:0] OP_PASS_B    = 4'h7;
    localparam logic [3:0] OP_REG_WRITE = 4'h8;
    localparam logic [3:0] OP_REG_READ  = 4'h9;
    localparam logic [3:0] OP_ADD_REG   = 4'hA;
    localparam logic [3:0] OP_SUB_REG   = 4'hB;
    localparam logic [3:0] OP_MUL       = 4'hC;
    localparam logic [3:0] OP_ACC       = 4'hD;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_SIGN  = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// W-cycle shift-add unsigned multiplier. Operands latch on start; one partial
// product per enabled cycle, done/prod present the final sum during the last step.
module alu_mul_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    // prod is the combinational result of the current step, so the owner can
    // capture the full product on the same edge that retires the last step.
    assign prod     = acc_next;
    assign done     = ena && busy && (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (ena) begin
            if (start) begin
                mcand  <= {{W{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (done) busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_regfile_mc.sv
// W-bit ALU with a DEPTH-entry register file, valid/ready handshakes and a
// sequential multiplier; results and flags are held until the consumer takes them.
import alu_pkg::*;

module alu_regfile_mc #(
    parameter int  W     = 4,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [AW-1:0] addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic [3:0]    flags
);

    localparam logic [W-1:0] W_MOD = W'(W);

    state_t         state, state_next;
    logic [W-1:0]   rf [DEPTH];
    logic           accept, load, mul_start, mul_busy, mul_done;
    logic [2*W-1:0] mul_prod;

    logic [W-1:0] rval, opnd_y, y_eff, sh_amt, alu_res, ld_res;
    logic [W:0]   sum;
    logic         sub_mode, sum_ovf, alu_c, alu_v, ld_c, ld_v;
    logic [3:0]   ld_flags;

    assign in_ready  = ena && (state == IDLE) && !mul_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign load      = (accept && (op != OP_MUL)) || mul_done;

    alu_mul_seq #(.W(W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // One W+1 bit adder serves every add/subtract flavour; subtraction is A + ~Y + 1.
    always_comb begin
        rval     = rf[addr];
        opnd_y   = b;
        sub_mode = 1'b0;
        case (op)
            OP_SUB:     sub_mode = 1'b1;
            OP_ADD_REG: opnd_y   = rval;
            OP_SUB_REG: begin opnd_y = rval; sub_mode = 1'b1; end
            OP_ACC:     opnd_y   = rval;
            default:    ;
        endcase
        y_eff   = sub_mode ? ~opnd_y : opnd_y;
        sum     = {1'b0, a} + {1'b0, y_eff} + {{W{1'b0}}, sub_mode};
        sum_ovf = (a[W-1] == y_eff[W-1]) && (sum[W-1] != a[W-1]);
        sh_amt  = b % W_MOD;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADD_REG, OP_SUB_REG, OP_ACC: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = sum_ovf;
            end
            OP_AND:      alu_res = a & b;
            OP_OR:       alu_res = a | b;
            OP_XOR:      alu_res = a ^ b;
            OP_SHL:      alu_res = a << sh_amt;
            OP_SHR:      alu_res = a >> sh_amt;
            OP_PASS_B:   alu_res = b;
            OP_REG_READ: alu_res = rval;
            default:     ;
        endcase
    end

    always_comb begin
        ld_res   = mul_done ? mul_prod[W-1:0] : alu_res;
        ld_c     = mul_done ? |mul_prod[2*W-1:W] : alu_c;
        ld_v     = mul_done ? |mul_prod[2*W-1:W] : alu_v;
        ld_flags = '0;
        ld_flags[FLAG_ZERO]  = (ld_res == '0);
        ld_flags[FLAG_SIGN]  = ld_res[W-1];
        ld_flags[FLAG_OVF]   = ld_v;
        ld_flags[FLAG_CARRY] = ld_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (accept && (op == OP_REG_WRITE)) begin
            rf[addr] <= a;
        end else if (accept && (op == OP_ACC)) begin
            rf[addr] <= sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flags     <= 4'b1000;
            out_valid <= 1'b0;
        end else if (ena) begin
            if (load) begin
                result    <= ld_res;
                flags     <= ld_flags;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= IDLE;
        else if (ena) state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = MUL_RUN;
            MUL_RUN: if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile_mc.sv
// Bench for alu_regfile_mc: directed scenarios plus random traffic, all checked
// every cycle against an arithmetic reference model of the block.
module tb_alu_regfile_mc;

    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int MOD   = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [AW-1:0] addr = '0;
    logic          in_ready, out_valid;
    logic [W-1:0]  result;
    logic [3:0]    flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_regfile_mc #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         wr;
        logic [W-1:0] wval;
    } ref_t;

    function automatic int sx(int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic void arith(input int x, input int y, input bit sub,
                                  output int r, output bit c, output bit v);
        int sr;
        sr = sub ? sx(x) - sx(y) : sx(x) + sx(y);
        r  = sub ? (x - y + MOD) % MOD : (x + y) % MOD;
        c  = sub ? (x >= y) : (x + y >= MOD);
        v  = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
    endfunction

    function automatic ref_t ref_op(input int o, input int ua, input int ub, input int ur);
        ref_t t;
        int   r;
        bit   c, v;
        r = 0; c = 0; v = 0;
        t.wr = 1'b0; t.wval = '0;
        case (o)
            0:  arith(ua, ub, 1'b0, r, c, v);
            1:  arith(ua, ub, 1'b1, r, c, v);
            2:  r = ua & ub;
            3:  r = ua | ub;
            4:  r = ua ^ ub;
            5:  r = (ua << (ub % W)) % MOD;
            6:  r = ua >> (ub % W);
            7:  r = ub;
            8:  begin t.wr = 1'b1; t.wval = ua[W-1:0]; end
            9:  r = ur;
            10: arith(ua, ur, 1'b0, r, c, v);
            11: arith(ua, ur, 1'b1, r, c, v);
            12: begin r = (ua * ub) % MOD; c = (ua * ub) >= MOD; v = c; end
            13: begin arith(ur, ua, 1'b0, r, c, v); t.wr = 1'b1; t.wval = r[W-1:0]; end
            default: r = 0;
        endcase
        t.res = r[W-1:0];
        t.fl  = {r == 0, r >= MOD / 2, v, c};
        return t;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: pending multiply counts down enabled cycles.
    logic [W-1:0] m_res = '0;
    logic [3:0]   m_fl = 4'b1000;
    logic         m_ov = 1'b0;
    int           m_cnt = 0;
    ref_t         m_mul = '0;
    logic [W-1:0] m_rf [DEPTH];
    ref_t         m_t;
    logic         m_ready;

    assign m_ready = ena && (m_cnt == 0) && (!m_ov || out_ready);
    assign m_t     = ref_op(int'(op), int'(a), int'(b), int'(m_rf[addr]));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res <= '0; m_fl <= 4'b1000; m_ov <= 1'b0; m_cnt <= 0; m_mul <= '0;
            for (int i = 0; i < DEPTH; i++) m_rf[i] <= '0;
        end else if (ena) begin
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_res <= m_mul.res; m_fl <= m_mul.fl; m_ov <= 1'b1;
                end
            end else if (in_valid && m_ready) begin
                if (op == 4'hC) begin
                    m_cnt <= W; m_mul <= m_t; m_ov <= 1'b0;
                end else begin
                    m_res <= m_t.res; m_fl <= m_t.fl; m_ov <= 1'b1;
                    if (m_t.wr) m_rf[addr] <= m_t.wval;
                end
            end else if (m_ov && out_ready) begin
                m_ov <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  int'(in_ready),  int'(m_ready));
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("result",    int'(result),    int'(m_res));
        chk("flags",     int'(flags),     int'(m_fl));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [AW-1:0] ad);
        logic got;
        op = o; a = xa; b = xb; addr = ad; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1 got = in_ready;
            tick();
            if (got) begin in_valid = 1'b0; return; end
        end
        in_valid = 1'b0;
        checks++; errors++;
        $display("FAIL issue_timeout: op %0h never accepted", o);
    endtask

    initial begin
        ref_t p;
        int   n;

        p = ref_op(0, 7, 1, 0);   chk("pin_add", int'({p.res, p.fl}), 'h86);
        p = ref_op(1, 3, 5, 0);   chk("pin_sub", int'({p.res, p.fl}), 'hE4);
        p = ref_op(12, 13, 11, 0); chk("pin_mul", int'({p.res, p.fl}), 'hF7);
        p = ref_op(13, 9, 0, 9);  chk("pin_acc", int'({p.res, p.fl, p.wval}), 'h232);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'(flags), 'h8);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        issue(4'h0, 4'd7, 4'd1, 3'd0);
        chk("add_7_1", int'({out_valid, result, flags}), 'h186);
        issue(4'h1, 4'd3, 4'd5, 3'd0);
        chk("sub_3_5", int'({out_valid, result, flags}), 'h1E4);

        issue(4'hC, 4'd13, 4'd11, 3'd0);
        for (int k = 0; k < W; k++) begin
            chk("mul_busy", int'({in_ready, out_valid}), 0);
            tick();
        end
        chk("mul_13_11", int'({out_valid, result, flags}), 'h1F7);

        issue(4'h8, 4'd9, 4'd0, 3'd5);
        chk("regwrite", int'({result, flags}), 'h08);
        issue(4'hD, 4'd9, 4'd0, 3'd5);
        chk("acc_9", int'({result, flags}), 'h23);
        issue(4'h9, 4'd0, 4'd0, 3'd5);
        chk("regread_5", int'({result, flags}), 'h20);

        tick();
        out_ready = 1'b0;
        issue(4'h0, 4'd2, 4'd3, 3'd0);
        op = 4'h0; a = 4'd1; b = 4'd1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold", int'({in_ready, out_valid, result}), 'h15);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bp_second", int'({out_valid, result}), 'h12);

        issue(4'hC, 4'd15, 4'd15, 3'd0);
        tick();
        rst_n = 1'b0;
        #1 chk("midmul_reset", int'({out_valid, result, flags}), 'h008);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("no_partial", int'(out_valid), 0);
            tick();
        end

        issue(4'hC, 4'd13, 4'd11, 3'd0);
        tick();
        n = 1;
        ena = 1'b0;
        repeat (3) begin tick(); n++; end
        ena = 1'b1;
        while (!out_valid && n < 30) begin tick(); n++; end
        chk("ena_stretch_edges", n, W + 3);
        chk("ena_stretch_result", int'({result, flags}), 'hF7);

        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            op        = 4'($urandom_range(0, 15));
            a         = W'($urandom);
            b         = W'($urandom);
            addr      = AW'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0; ena = 1'b1; out_ready = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
